solver_scheduler: RTL and testbench

SOLVER_SCHEDULER -- requirements
Module: solver_scheduler

---
 rtl/solver_scheduler_if.sv | 36 +++
 rtl/solver_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_solver_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/solver_scheduler_if.sv
// Job-input, solver-side and result-side signals of the solver scheduler.
// The scheduler takes the slave view; the job source, solvers and result sink take the master view.
interface solver_scheduler_if #(
  parameter int NUM_SOLVERS     = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27,
  parameter int TAG_BITS        = 8
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [LIMB_SIZE_BITS-1:0]             in_data;
  logic [NUM_SOLVERS-1:0]                sol_wr_real_en;
  logic [NUM_SOLVERS-1:0]                sol_wr_imag_en;
  logic [LIMB_INDEX_BITS-1:0]            sol_wr_limb;
  logic [LIMB_SIZE_BITS-1:0]             sol_wr_data;
  logic [NUM_SOLVERS-1:0]                sol_start;
  logic [NUM_SOLVERS-1:0]                sol_out_ready;
  logic [NUM_SOLVERS*LIMB_SIZE_BITS-1:0] sol_iterations;
  logic                                  res_valid;
  logic                                  res_ready;
  logic [TAG_BITS-1:0]                   res_tag;
  logic [LIMB_SIZE_BITS-1:0]             res_iterations;
  logic [NUM_SOLVERS-1:0]                busy_mask;

  modport master (
    output in_valid, in_data, sol_out_ready, sol_iterations, res_ready,
    input  in_ready, sol_wr_real_en, sol_wr_imag_en, sol_wr_limb, sol_wr_data,
           sol_start, res_valid, res_tag, res_iterations, busy_mask
  );

  modport slave (
    input  in_valid, in_data, sol_out_ready, sol_iterations, res_ready,
    output in_ready, sol_wr_real_en, sol_wr_imag_en, sol_wr_limb, sol_wr_data,
           sol_start, res_valid, res_tag, res_iterations, busy_mask
  );
endinterface

// File: rtl/solver_scheduler.sv
// Dispatches limb-serial jobs to the lowest free solver and returns solver results
// through a single round-robin arbitrated result register.
module solver_scheduler #(
  parameter int NUM_SOLVERS     = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27,
  parameter int NUM_LIMBS       = 4,
  parameter int TAG_BITS        = 8
) (
  input  logic              clock,
  input  logic              reset,
  solver_scheduler_if.slave bus
);
  localparam int SEL_W  = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int BEAT_W = $clog2(2 * NUM_LIMBS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * NUM_LIMBS - 1);
  localparam logic [BEAT_W-1:0] IMAG_BEAT = BEAT_W'(NUM_LIMBS);

  typedef enum logic [1:0] {IDLE, LOAD, START} state_e;

  state_e                     state_q;
  logic [SEL_W-1:0]           target_q;
  logic [BEAT_W-1:0]          beat_q;
  logic                       in_ready_q;
  logic [NUM_SOLVERS-1:0]     start_q;
  logic [NUM_SOLVERS-1:0]     start_prev_q;
  logic [TAG_BITS-1:0]        job_cnt_q;
  logic [TAG_BITS-1:0]        tag_q [NUM_SOLVERS];
  logic [NUM_SOLVERS-1:0]     busy_q, busy_d;
  logic [SEL_W-1:0]           rr_q;
  logic                       res_valid_q;
  logic [TAG_BITS-1:0]        res_tag_q;
  logic [LIMB_SIZE_BITS-1:0]  res_iter_q;

  logic                       free_found;
  logic [SEL_W-1:0]           free_idx;
  logic [NUM_SOLVERS-1:0]     target_oh;
  logic                       accept;
  logic                       imag_beat;
  logic [BEAT_W-1:0]          limb_idx;
  logic [NUM_SOLVERS-1:0]     cand;
  logic                       res_load;
  logic                       grant_hit;
  logic                       grant_fire;
  logic [SEL_W-1:0]           grant_idx;
  logic [NUM_SOLVERS-1:0]     grant_oh;
  logic [TAG_BITS-1:0]        grant_tag;
  logic [LIMB_SIZE_BITS-1:0]  grant_iter;

  // Lowest-index free solver, taken from registered busy bits only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = SEL_W'(i);
      end
    end
  end

  assign target_oh = NUM_SOLVERS'(1) << target_q;
  assign accept    = in_ready_q & bus.in_valid;
  assign imag_beat = beat_q >= IMAG_BEAT;
  assign limb_idx  = imag_beat ? beat_q - IMAG_BEAT : beat_q;

  assign bus.in_ready       = in_ready_q;
  assign bus.sol_wr_real_en = (accept && !imag_beat) ? target_oh : '0;
  assign bus.sol_wr_imag_en = (accept &&  imag_beat) ? target_oh : '0;
  assign bus.sol_wr_limb    = LIMB_INDEX_BITS'(limb_idx);
  assign bus.sol_wr_data    = bus.in_data;
  assign bus.sol_start      = start_q;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      target_q     <= '0;
      beat_q       <= '0;
      in_ready_q   <= 1'b0;
      start_q      <= '0;
      start_prev_q <= '0;
      job_cnt_q    <= '0;
    end else begin
      start_prev_q <= start_q;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && free_found) begin
            state_q    <= LOAD;
            target_q   <= free_idx;
            beat_q     <= '0;
            in_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q    <= START;
              in_ready_q <= 1'b0;
              start_q    <= target_oh;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        START: begin
          start_q   <= '0;
          job_cnt_q <= job_cnt_q + 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag storage is left unreset; a tag is only read once its solver is busy,
  // and busy is only set on the same edge that writes the tag.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (state_q == START && target_q == SEL_W'(i)) tag_q[i] <= job_cnt_q;
    end
  end

  // A solver started this cycle or last cycle may still show its previous out_ready.
  assign cand     = busy_q & bus.sol_out_ready & ~start_q & ~start_prev_q;
  assign res_load = !res_valid_q || bus.res_ready;

  always_comb begin
    grant_hit  = 1'b0;
    grant_idx  = '0;
    grant_tag  = '0;
    grant_iter = '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (!grant_hit && cand[i] && SEL_W'(i) >= rr_q) begin
        grant_hit = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (!grant_hit && cand[i]) begin
        grant_hit = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_tag  = tag_q[i];
        grant_iter = bus.sol_iterations[i*LIMB_SIZE_BITS +: LIMB_SIZE_BITS];
      end
    end
  end

  assign grant_fire = res_load && grant_hit;
  assign grant_oh   = grant_fire ? (NUM_SOLVERS'(1) << grant_idx) : '0;
  // The dispatch target is never busy, so set and clear cannot collide.
  assign busy_d     = (busy_q | ((state_q == START) ? target_oh : '0)) & ~grant_oh;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= '0;
      rr_q        <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_iter_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (res_load) begin
        res_valid_q <= grant_hit;
        if (grant_hit) begin
          res_tag_q  <= grant_tag;
          res_iter_q <= grant_iter;
          rr_q       <= (grant_idx == SEL_W'(NUM_SOLVERS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  assign bus.res_valid      = res_valid_q;
  assign bus.res_tag        = res_tag_q;
  assign bus.res_iterations = res_iter_q;
  assign bus.busy_mask      = busy_q;
endmodule

// File: tb/tb_solver_scheduler.sv
// Self-checking bench for solver_scheduler: emulated solvers, random job/result traffic,
// and a transaction-level reference model checked every cycle plus directed scenarios.
module tb_solver_scheduler;
  localparam int NS  = 4;
  localparam int LIB = 6;
  localparam int LW  = 27;
  localparam int NL  = 4;
  localparam int TW  = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  solver_scheduler_if #(.NUM_SOLVERS(NS), .LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LW),
                        .TAG_BITS(TW)) bus ();

  solver_scheduler #(.NUM_SOLVERS(NS), .LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LW),
                     .NUM_LIMBS(NL), .TAG_BITS(TW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus state: pending job beats, traffic knobs, emulated solvers.
  logic [LW-1:0] beats[$];
  int cyc = 0;
  int p_valid = 100;
  int p_ready = 100;
  int lat_lo  = 1;
  int lat_hi  = -1;
  bit            rdy[NS];
  logic [LW-1:0] iter[NS];
  int            drop_at[NS];
  int            done_at[NS];

  // Reference model: job in flight, solver occupancy, tags, result slot.
  bit            m_busy[NS];
  int            m_tag[NS];
  int            last_start[NS];
  int            m_jobs, m_rr, m_tgt, m_beats;
  bit            m_rv;
  int            m_rt;
  logic [LW-1:0] m_ri;

  int first_start;
  int last_acc_tag;
  bit saw_255, saw_wrap;

  function automatic logic [NS-1:0] busy_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic push_job();
    repeat (2 * NL) beats.push_back(LW'($urandom));
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    beats.delete();
    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.res_ready      = 1'b0;
    bus.sol_out_ready  = '0;
    bus.sol_iterations = '0;
    for (int i = 0; i < NS; i++) begin
      rdy[i] = 1'b0; iter[i] = '0; drop_at[i] = -1; done_at[i] = -1;
      m_busy[i] = 1'b0; m_tag[i] = 0; last_start[i] = -100;
    end
    repeat (n) begin @(posedge clock); #1; cyc++; end
    reset = 1'b0;
    m_jobs = 0; m_rr = 0; m_tgt = -1; m_beats = 0;
    m_rv = 1'b0; m_rt = 0; m_ri = '0;
    first_start = -1; last_acc_tag = -1; saw_255 = 1'b0; saw_wrap = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (cyc == drop_at[i]) rdy[i] = 1'b0;
      if (cyc == done_at[i]) begin rdy[i] = 1'b1; iter[i] = LW'($urandom); end
      bus.sol_out_ready[i] = rdy[i];
      bus.sol_iterations[i*LW +: LW] = iter[i];
    end
    bus.in_valid = (beats.size() > 0) && ($urandom_range(99) < p_valid);
    if (beats.size() > 0) bus.in_data = beats[0];
    bus.res_ready = ($urandom_range(99) < p_ready);
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic tick();
    bit            iv, rr_in, exp_ir, acc;
    logic [NS-1:0] exp_re, exp_ie, exp_st;
    bit            busy_old[NS];
    int            s, g;
    drive();
    #1;
    iv = bus.in_valid;
    rr_in = bus.res_ready;
    exp_ir = (m_tgt >= 0) && (m_beats < 2 * NL);
    acc = exp_ir && iv;
    exp_re = '0; exp_ie = '0; exp_st = '0;
    if (acc && m_beats < NL)  exp_re[m_tgt] = 1'b1;
    if (acc && m_beats >= NL) exp_ie[m_tgt] = 1'b1;
    if (m_tgt >= 0 && m_beats == 2 * NL) exp_st[m_tgt] = 1'b1;
    check("in_ready", bus.in_ready, exp_ir);
    check("wr_real_en", bus.sol_wr_real_en, exp_re);
    check("wr_imag_en", bus.sol_wr_imag_en, exp_ie);
    if (acc) check("wr_limb", bus.sol_wr_limb, m_beats % NL);
    check("wr_data", bus.sol_wr_data, bus.in_data);
    check("sol_start", bus.sol_start, exp_st);
    check("res_valid", bus.res_valid, m_rv);
    if (m_rv) begin
      check("res_tag", bus.res_tag, m_rt);
      check("res_iter", bus.res_iterations, m_ri);
    end
    check("busy_mask", bus.busy_mask, busy_vec());

    if (bus.sol_start != 0 && first_start < 0) first_start = cyc;
    if (bus.res_valid && rr_in) begin
      last_acc_tag = int'(bus.res_tag);
      if (last_acc_tag == 255) saw_255 = 1'b1;
      else if (last_acc_tag == 0 && saw_255) saw_wrap = 1'b1;
    end

    busy_old = m_busy;
    s = -1;
    if (m_tgt < 0) begin
      if (iv) begin
        for (int i = 0; i < NS; i++) if (m_tgt < 0 && !busy_old[i]) m_tgt = i;
        m_beats = 0;
      end
    end else if (m_beats < 2 * NL) begin
      if (iv) begin void'(beats.pop_front()); m_beats++; end
    end else begin
      s = m_tgt;
    end
    if (!m_rv || rr_in) begin
      g = -1;
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (m_rr + k) % NS;
        if (g < 0 && busy_old[idx] && rdy[idx] && (cyc - last_start[idx] > 1)) g = idx;
      end
      if (g >= 0) begin
        m_rv = 1'b1; m_rt = m_tag[g]; m_ri = iter[g];
        m_busy[g] = 1'b0; m_rr = (g + 1) % NS;
      end else begin
        m_rv = 1'b0;
      end
    end
    if (s >= 0) begin
      m_busy[s] = 1'b1;
      m_tag[s] = m_jobs % (1 << TW);
      m_jobs++;
      last_start[s] = cyc;
      m_tgt = -1;
      drop_at[s] = cyc + 2;
      done_at[s] = (lat_hi < 0) ? -1 : cyc + 2 + int'($urandom_range(lat_hi, lat_lo));
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  initial begin
    int c0;

    // Reset state
    do_reset(2);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_busy", bus.busy_mask, 4'b0000);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_tag", bus.res_tag, 8'd0);
    check("rst_res_iter", bus.res_iterations, 27'd0);
    check("rst_sol_start", bus.sol_start, 4'b0000);
    check("rst_wr_real", bus.sol_wr_real_en, 4'b0000);
    check("rst_wr_imag", bus.sol_wr_imag_en, 4'b0000);

    // Single job with continuous valid: start 9 cycles after leaving IDLE
    lat_hi = -1; p_valid = 100; p_ready = 100;
    push_job();
    c0 = cyc;
    run(12);
    check("single_start_cycle", first_start - c0, 9);
    check("single_busy", bus.busy_mask, 4'b0001);
    done_at[0] = cyc;
    run(3);
    check("single_res_tag", last_acc_tag, 0);
    check("single_busy_clear", bus.busy_mask, 4'b0000);

    // Five jobs, nothing completes: fifth waits, then takes the freed solver with tag 4
    do_reset(1);
    lat_hi = -1;
    repeat (5) push_job();
    run(60);
    check("full_busy", bus.busy_mask, 4'b1111);
    check("full_in_ready", bus.in_ready, 1'b0);
    check("full_no_start", bus.sol_start, 4'b0000);
    done_at[2] = cyc;
    run(20);
    check("refill_busy", bus.busy_mask, 4'b1111);
    done_at[2] = cyc;
    run(4);
    check("fifth_tag", last_acc_tag, 4);

    // Solvers 1 and 3 finish together: 1 first, then 3
    do_reset(1);
    lat_hi = -1;
    repeat (4) push_job();
    run(50);
    done_at[1] = cyc;
    done_at[3] = cyc;
    tick();
    check("pair_first_valid", bus.res_valid, 1'b1);
    check("pair_first_tag", bus.res_tag, 8'd1);
    check("pair_first_busy", bus.busy_mask, 4'b1101);
    tick();
    check("pair_second_tag", bus.res_tag, 8'd3);
    check("pair_second_busy", bus.busy_mask, 4'b0101);

    // Back-pressure: pending result held, other candidates wait
    p_ready = 0;
    done_at[0] = cyc;
    done_at[2] = cyc;
    run(10);
    check("hold_valid", bus.res_valid, 1'b1);
    check("hold_tag", bus.res_tag, 8'd3);
    check("hold_busy", bus.busy_mask, 4'b0101);
    p_ready = 100;
    run(6);
    check("drain_busy", bus.busy_mask, 4'b0000);

    // Reset after three LOAD beats discards the job
    do_reset(1);
    lat_hi = -1;
    repeat (2) push_job();
    run(4);
    do_reset(1);
    check("midload_in_ready", bus.in_ready, 1'b0);
    check("midload_busy", bus.busy_mask, 4'b0000);
    check("midload_start", bus.sol_start, 4'b0000);
    run(12);
    check("midload_no_start", first_start, -1);
    lat_lo = 1; lat_hi = 4;
    push_job();
    run(25);
    check("midload_next_tag", last_acc_tag, 0);

    // Tag wrap over 260 back-to-back jobs
    do_reset(1);
    lat_lo = 1; lat_hi = 3; p_valid = 100; p_ready = 100;
    repeat (260) push_job();
    for (int n = 0; n < 6000 && beats.size() > 0; n++) tick();
    run(30);
    check("wrap_drained", beats.size(), 0);
    check("wrap_seen", saw_wrap, 1'b1);

    // Random traffic
    do_reset(1);
    lat_lo = 1; lat_hi = 25; p_valid = 70; p_ready = 60;
    repeat (40) push_job();
    for (int n = 0; n < 5000 && beats.size() > 0; n++) tick();
    p_ready = 100;
    run(60);
    check("rand_drained", beats.size(), 0);
    check("rand_busy_final", bus.busy_mask, 4'b0000);
    check("rand_res_final", bus.res_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
